mod_counter: RTL and testbench

Parametrised modulo-N wrap counter with carry-in and combinational carry-out, generalising the fixed-width minutes counter into one reusable stage for the clock datapath (seconds, minutes, hours). Adds up/down counting, synchronous load with range clamping, a programmable reset value and a registered wrap pulse. Stages chain by wiring one stage's `co` to the next stage's `inc`, and all stages advance on the same edge.

---
 rtl/mod_counter.sv | 82 ++++++++
 tb/tb_mod_counter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// Modulo-MODULUS wrap counter stage with carry-in and combinational carry-out for chaining.
// Optional feature macro: MOD_COUNTER_DOWN_EN enables down counting (dir) and borrow on co.
module mod_counter #(
   parameter int MODULUS = 60,
   parameter int W       = 7,
   parameter int RST_VAL = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         dir,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count,
   output logic         co,
   output logic         wrap,
   output logic         load_err
);

   localparam logic [W:0]   MAX_EXT = (W+1)'(MODULUS - 1);
   localparam logic [W:0]   MOD_EXT = (W+1)'(MODULUS);
   localparam logic [W-1:0] MAX_V   = W'(MODULUS - 1);
   localparam logic [W-1:0] RST_V   = W'(RST_VAL);

   logic [W:0]   cnt_ext;
   logic [W:0]   up_ext;
   logic [W:0]   step_ext;
   logic [W-1:0] step_val;
   logic [W-1:0] load_sel;
   logic         at_max;
   logic         hit;
   logic         load_ok;
   logic         unused_msb;

   // One extra bit keeps MODULUS = 2^W from aliasing back onto 0 in the compares.
   assign cnt_ext = {1'b0, count};
   assign at_max  = (cnt_ext == MAX_EXT);
   assign up_ext  = at_max ? '0 : cnt_ext + 1'b1;

`ifdef MOD_COUNTER_DOWN_EN
   logic         at_zero;
   logic [W:0]   dn_ext;

   assign at_zero  = (count == '0);
   assign dn_ext   = at_zero ? MAX_EXT : cnt_ext - 1'b1;
   assign hit      = dir ? at_zero : at_max;
   assign step_ext = dir ? dn_ext : up_ext;
`else
   logic         unused_dir;

   assign unused_dir = dir;
   assign hit        = at_max;
   assign step_ext   = up_ext;
`endif

   assign step_val   = step_ext[W-1:0];
   assign unused_msb = step_ext[W];

   // Out-of-range loads clamp to the top of the range.
   assign load_ok  = ({1'b0, load_val} < MOD_EXT);
   assign load_sel = load_ok ? load_val : MAX_V;

   assign co = rst & inc & ~load & hit;

   always_ff @(posedge clk) begin
      if (!rst) begin
         count    <= RST_V;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else if (load) begin
         count    <= load_sel;
         wrap     <= 1'b0;
         load_err <= ~load_ok;
      end else begin
         wrap     <= inc & hit;
         load_err <= 1'b0;
         if (inc)
            count <= step_val;
      end
   end

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: seconds->minutes chain (60/60) plus a power-of-two stage (8),
// checked against an arithmetic modulo model, directed steps then random traffic.
module tb_mod_counter;

`ifdef MOD_COUNTER_DOWN_EN
   localparam bit DOWN = 1'b1;
`else
   localparam bit DOWN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, inc, dir;
   logic       load_a, load_m, load_p;
   logic [6:0] lv_a, lv_m;
   logic [2:0] lv_p;
   logic [6:0] count_a, count_m;
   logic [2:0] count_p;
   logic       co_a, co_m, co_p;
   logic       wrap_a, wrap_m, wrap_p;
   logic       lerr_a, lerr_m, lerr_p;

   int checks = 0;
   int failures = 0;
   int ma = 0, mm = 0, mp = 0;
   int wa, wm, wp, ea, em, ep;

   always #5 clk = ~clk;

   mod_counter #(.MODULUS(60), .W(7), .RST_VAL(5)) u_sec (
      .clk(clk), .rst(rst), .inc(inc), .dir(dir), .load(load_a), .load_val(lv_a),
      .count(count_a), .co(co_a), .wrap(wrap_a), .load_err(lerr_a));

   mod_counter #(.MODULUS(60), .W(7), .RST_VAL(0)) u_min (
      .clk(clk), .rst(rst), .inc(co_a), .dir(dir), .load(load_m), .load_val(lv_m),
      .count(count_m), .co(co_m), .wrap(wrap_m), .load_err(lerr_m));

   mod_counter #(.MODULUS(8), .W(3), .RST_VAL(0)) u_pow2 (
      .clk(clk), .rst(rst), .inc(inc), .dir(dir), .load(load_p), .load_val(lv_p),
      .count(count_p), .co(co_p), .wrap(wrap_p), .load_err(lerr_p));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: next value is (c +/- 1) mod m; co computed from the pre-edge state.
   task automatic model(input int m, input int rv, input bit r, input bit i, input bit d,
                        input bit l, input int lv, inout int c,
                        output int w, output int e, output int co);
      bit dn;
      dn = DOWN && d;
      co = (r && i && !l && (dn ? (c == 0) : (c == m - 1))) ? 1 : 0;
      w  = 0;
      e  = 0;
      if (!r)
         c = rv;
      else if (l) begin
         if (lv < m) c = lv;
         else begin
            c = m - 1;
            e = 1;
         end
      end else if (i) begin
         w = (dn ? (c == 0) : (c == m - 1)) ? 1 : 0;
         c = dn ? (c + m - 1) % m : (c + 1) % m;
      end
   endtask

   task automatic step(input bit r, input bit i, input bit d,
                       input bit la, input int va, input bit lm, input int vm,
                       input bit lp, input int vp);
      int coa, com, cop;
      rst = r; inc = i; dir = d;
      load_a = la; lv_a = 7'(va);
      load_m = lm; lv_m = 7'(vm);
      load_p = lp; lv_p = 3'(vp);
      model(60, 5, r, i, d, la, va, ma, wa, ea, coa);
      model(60, 0, r, coa[0], d, lm, vm, mm, wm, em, com);
      model(8, 0, r, i, d, lp, vp, mp, wp, ep, cop);
      #1;
      chk("co_sec", co_a, coa);
      chk("co_min", co_m, com);
      chk("co_pow2", co_p, cop);
      @(posedge clk); #1;
      chk("count_sec", count_a, ma);
      chk("wrap_sec", wrap_a, wa);
      chk("lerr_sec", lerr_a, ea);
      chk("count_min", count_m, mm);
      chk("wrap_min", wrap_m, wm);
      chk("lerr_min", lerr_m, em);
      chk("count_pow2", count_p, mp);
      chk("wrap_pow2", wrap_p, wp);
      chk("lerr_pow2", lerr_p, ep);
   endtask

   initial begin
      rst = 1'b0; inc = 1'b0; dir = 1'b0;
      load_a = 1'b0; load_m = 1'b0; load_p = 1'b0;
      lv_a = '0; lv_m = '0; lv_p = '0;
      @(posedge clk); #1;

      // reset held two cycles with inc/load active, then release
      step(0, 1, 0, 1, 3, 1, 4, 1, 2);
      step(0, 1, 0, 1, 3, 1, 4, 1, 2);
      step(1, 1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0, 0);

      // up wrap 58 -> 59 -> 0 -> 1, minutes steps once
      step(1, 0, 0, 1, 58, 1, 0, 1, 0);
      repeat (3) step(1, 1, 0, 0, 0, 0, 0, 0, 0);

      // down wrap 1 -> 0 -> 59 -> 58 (count up when the feature is off)
      step(1, 0, 0, 1, 1, 0, 0, 0, 0);
      repeat (3) step(1, 1, 1, 0, 0, 0, 0, 0, 0);

      // clamped load with inc in the same cycle, then pulse clears
      step(1, 1, 0, 1, 100, 1, 127, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 1, 60, 1, 59, 1, 7);

      // chain rollover 59:59 -> 0:0
      step(1, 0, 0, 1, 59, 1, 59, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0, 0);

      // power-of-two modulus: 9 increments from 0, then down steps
      step(1, 0, 0, 0, 0, 0, 0, 1, 0);
      repeat (9) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) step(1, 1, 1, 0, 0, 0, 0, 0, 0);

      // reset mid-count overrides load and inc
      step(1, 1, 0, 1, 57, 1, 30, 1, 6);
      step(0, 1, 1, 1, 50, 1, 10, 1, 3);
      step(1, 1, 1, 0, 0, 0, 0, 0, 0);

      repeat (400)
         step($urandom_range(0, 15) != 0, 1'($urandom), 1'($urandom),
              $urandom_range(0, 7) == 0, $urandom_range(0, 127),
              $urandom_range(0, 7) == 0, $urandom_range(0, 127),
              $urandom_range(0, 7) == 0, $urandom_range(0, 7));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
